sensor_err_mon: RTL
===================

SENSOR_ERR_MON -- requirements
Module: sensor_err_mon

Interface
REQ-001 Parameter: DEBOUNCE, default 3, number of consecutive high error samples that qualify an alarm; legal range 1..15.
REQ-002 Port: clk  input  1  system clock; all state changes on the rising edge.
REQ-003 Port: n_rst  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 Port: error  input  1  sensor error flag from the sensor decode logic; synchronous to clk.
REQ-005 Port: ack  input  1  host acknowledge of an active alarm.
REQ-006 Port: alarm  output  1  registered level; high while an unacknowledged qualified error is active.
REQ-007 Port: alarm_pulse  output  1  registered; one-cycle strobe on entry to ALARM.
REQ-008 Port: err_count  output  8  registered count of ALARM entries since reset.
REQ-009 Port: cnt_sat  output  1  registered; high when err_count = 255.

Function
REQ-010 FSM states: IDLE, QUAL, ALARM, HOLD; 4-bit debounce counter qcnt.
REQ-011 IDLE, error=1: go QUAL with qcnt=1; if DEBOUNCE=1, go ALARM directly.
REQ-012 IDLE, error=0: stay, qcnt=0.
REQ-013 QUAL, error=1: qcnt+1; if qcnt+1 = DEBOUNCE, go ALARM, else stay.
REQ-014 QUAL, error=0: go IDLE, qcnt=0; no partial credit retained.
REQ-015 Latency: alarm rises at the same edge that samples the DEBOUNCE-th consecutive error=1.
REQ-016 ALARM: alarm=1. ack=1 & error=0 -> IDLE; ack=1 & error=1 -> HOLD; ack=0 -> stay, regardless of error.
REQ-017 HOLD: alarm=0; stay while error=1; error=0 -> IDLE. No re-alarm occurs without an intervening IDLE.
REQ-018 ack in IDLE, QUAL or HOLD is ignored.
REQ-019 alarm_pulse=1 for exactly the first cycle in ALARM.
REQ-020 err_count increments by 1 on each ALARM entry; saturates at 255 with no wrap.
REQ-021 cnt_sat = (err_count = 255).
REQ-022 Error dropping then re-rising during ALARM does not create a new entry, pulse or count.
REQ-023 alarm and alarm_pulse are decoded from registered state only; ack and error have no combinational path to any output.

Reset
REQ-024 n_rst=0 sampled at a rising edge: state=IDLE, qcnt=0, alarm=0, alarm_pulse=0, err_count=0, cnt_sat=0.
REQ-025 Reset asserted mid-QUAL or mid-ALARM aborts the sequence; no pulse or count is produced.
REQ-026 Reset has priority over error and ack in the same cycle.
REQ-027 First cycle after release behaves as IDLE and samples error normally.

Configuration
REQ-028 Macro SENSOR_ERR_MON_CNT_EN defined: err_count and cnt_sat operate per REQ-020/021.
REQ-029 Macro SENSOR_ERR_MON_CNT_EN undefined: no counter register is built; err_count is tied to 0 and cnt_sat is tied to 0; ports remain present; FSM behaviour is unchanged.

Verification
REQ-030 DEBOUNCE=3; error=1 for 3 cycles after reset -> alarm=1 and alarm_pulse=1 after the 3rd edge; err_count=1.
REQ-031 DEBOUNCE=3; error pattern 1,1,0,1,1,0 -> alarm stays 0 throughout; err_count=0.
REQ-032 In ALARM, ack=1 with error=1 -> alarm=0 (HOLD); error held 5 more cycles -> no new pulse; error=0 -> IDLE.
REQ-033 DEBOUNCE=1; 300 isolated error/ack cycles -> err_count=255, cnt_sat=1, no wrap; with macro undefined -> err_count=0.
REQ-034 n_rst=0 during ALARM with error=1 -> next edge all outputs 0; after release, error=1 for DEBOUNCE cycles -> alarm re-qualifies.
REQ-035 ack=1 pulses in IDLE and QUAL -> no state or output change; ALARM with ack=0 for 10 cycles -> alarm held at 1.

Source files
------------

// File: rtl/sensor_err_mon.sv
// Debounced sensor-error alarm monitor with host acknowledge and a saturating alarm-entry counter.
// Define SENSOR_ERR_MON_CNT_EN to build err_count/cnt_sat; otherwise both outputs are tied to 0.
module sensor_err_mon #(
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       error,
    input  logic       ack,
    output logic       alarm,
    output logic       alarm_pulse,
    output logic [7:0] err_count,
    output logic       cnt_sat
);

    localparam int unsigned QCNT_W = 4;
    localparam int unsigned CNT_W  = 8;
    localparam logic [QCNT_W-1:0] DEB_THR = QCNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_QUAL  = 2'd1,
        S_ALARM = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [QCNT_W-1:0]   qcnt;
    logic [QCNT_W-1:0]   qcnt_nxt;
    logic [QCNT_W-1:0]   qcnt_inc;
    logic                entry_c;

    assign qcnt_inc = qcnt + QCNT_W'(1);

    // State register; alarm outputs are flops loaded from the next state.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= S_IDLE;
            qcnt        <= '0;
            alarm       <= 1'b0;
            alarm_pulse <= 1'b0;
        end else begin
            state       <= state_nxt;
            qcnt        <= qcnt_nxt;
            alarm       <= (state_nxt == S_ALARM);
            alarm_pulse <= entry_c;
        end
    end

    // Next-state and debounce counter logic.
    always_comb begin
        state_nxt = state;
        qcnt_nxt  = qcnt;
        entry_c   = 1'b0;

        unique case (state)
            S_IDLE: begin
                qcnt_nxt = '0;
                if (error) begin
                    if (DEB_THR == QCNT_W'(1)) begin
                        state_nxt = S_ALARM;
                    end else begin
                        state_nxt = S_QUAL;
                        qcnt_nxt  = QCNT_W'(1);
                    end
                end
            end
            S_QUAL: begin
                if (!error) begin
                    state_nxt = S_IDLE;
                    qcnt_nxt  = '0;
                end else if (qcnt_inc == DEB_THR) begin
                    state_nxt = S_ALARM;
                    qcnt_nxt  = '0;
                end else begin
                    qcnt_nxt  = qcnt_inc;
                end
            end
            S_ALARM: begin
                qcnt_nxt = '0;
                if (ack) begin
                    state_nxt = error ? S_HOLD : S_IDLE;
                end
            end
            S_HOLD: begin
                qcnt_nxt = '0;
                if (!error) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                qcnt_nxt  = '0;
            end
        endcase

        entry_c = (state_nxt == S_ALARM) && (state != S_ALARM);
    end

`ifdef SENSOR_ERR_MON_CNT_EN
    // Saturating count of ALARM entries; cnt_sat is set on the step that reaches the maximum.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            err_count <= '0;
            cnt_sat   <= 1'b0;
        end else if (entry_c && (err_count != CNT_MAX)) begin
            err_count <= err_count + CNT_W'(1);
            cnt_sat   <= (err_count == (CNT_MAX - CNT_W'(1)));
        end
    end
`else
    assign err_count = '0;
    assign cnt_sat   = 1'b0;
`endif

endmodule
